// File: rtl/pmc_dc_reg_bank.sv
// Purpose: N x 32-bit PMC digital-configuration register bank, OBI-style bus slave with HW update port.
// Latency: every granted request gets rvalid exactly RSP_LATENCY cycles later, fully pipelined, in order.
// Backpressure: none; gnt mirrors req, so one request per cycle is always accepted.
module pmc_dc_reg_bank #(
    parameter int unsigned         NUM_REGS    = 4,
    parameter logic [7:0]          BASE_OFFSET = 8'h00,
    parameter int unsigned         RSP_LATENCY = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = {NUM_REGS{1'b0}},
    parameter logic [31:0]         RESET_VAL   = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic                     gnt,
    output logic                     rvalid,
    output logic [31:0]              rdata,
    output logic                     err,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse,
    input  logic [NUM_REGS-1:0]      hw_we,
    input  logic [NUM_REGS*32-1:0]   hw_wdata
);

    // Window bounds in 9 bits so a window ending exactly at 256 still compares correctly.
    localparam logic [8:0] WIN_LO = {1'b0, BASE_OFFSET};
    localparam logic [8:0] WIN_HI = WIN_LO + 9'(4 * NUM_REGS);

    logic [8:0]          addr_lo;
    logic                mapped;
    logic [5:0]          idx;
    logic                unused_addr_hi;
    logic [NUM_REGS-1:0] wr_hit;
    logic                ro_hit;
    logic [31:0]         rd_val;
    logic                rsp_err;
    logic [31:0]         rsp_dat;

    logic [31:0]            regs_q [NUM_REGS];
    logic [31:0]            regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]    wr_pulse_q;
    logic [RSP_LATENCY-1:0] vld_q;
    logic [RSP_LATENCY-1:0] err_q;
    logic [31:0]            dat_q  [RSP_LATENCY];

    assign gnt            = req;
    assign addr_lo        = {1'b0, addr[7:0]};
    assign unused_addr_hi = ^addr[31:8];
    assign mapped         = (addr[1:0] == 2'b00) && (addr_lo >= WIN_LO) && (addr_lo < WIN_HI);
    assign idx            = 6'((addr[7:0] - BASE_OFFSET) >> 2);

    // Decode the selected register: read value, writable hit or read-only hit.
    always_comb begin
        wr_hit = '0;
        ro_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (mapped && (idx == 6'(i))) begin
                rd_val = regs_q[i];
                if (RO_MASK[i]) begin
                    ro_hit = 1'b1;
                end else begin
                    wr_hit[i] = req && we;
                end
            end
        end
    end

    // Response to enqueue this cycle; writes and errors always carry zero data.
    always_comb begin
        rsp_err = req && (!mapped || (we && ro_hit));
        rsp_dat = (req && !we && mapped) ? rd_val : 32'h0;
    end

    // Next register value: HW load first, then enabled bus bytes override it.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (hw_we[i]) begin
                regs_d[i] = hw_wdata[32*i +: 32];
            end
            if (wr_hit[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        regs_d[i][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Register storage and the one-cycle write-done pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            wr_pulse_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_pulse_q <= wr_hit;
        end
    end

    // Response shift register; reset drops anything still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int s = 0; s < RSP_LATENCY; s++) begin
                dat_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= req;
            err_q[0] <= rsp_err;
            dat_q[0] <= rsp_dat;
            for (int s = 1; s < RSP_LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                err_q[s] <= err_q[s-1];
                dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign rvalid   = vld_q[RSP_LATENCY-1];
    assign err      = err_q[RSP_LATENCY-1];
    assign rdata    = dat_q[RSP_LATENCY-1];
    assign wr_pulse = wr_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[32*g +: 32] = regs_q[g];
    end

endmodule

// File: tb/tb_pmc_dc_reg_bank.sv
// Purpose: directed checks of pmc_dc_reg_bank at response latencies 1, 3 and 2 sharing one stimulus.
// Latency: u1 checked at 1 cycle, u3 at 3 cycles, u2 at 2 cycles after grant.
// Backpressure: none; the DUT grants every request.
module tb_pmc_dc_reg_bank;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    hw_we;
    logic [127:0]  hw_wdata;

    logic          gnt1, rvalid1, err1;
    logic [31:0]   rdata1;
    logic [127:0]  regs1;
    logic [3:0]    wrp1;
    logic          gnt3, rvalid3, err3;
    logic [31:0]   rdata3;
    logic [127:0]  regs3;
    logic [3:0]    wrp3;
    logic          gnt2, rvalid2, err2;
    logic [31:0]   rdata2;
    logic [127:0]  regs2;
    logic [3:0]    wrp2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_tab [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

    pmc_dc_reg_bank #(.NUM_REGS(4), .BASE_OFFSET(8'h00), .RSP_LATENCY(1),
                      .RO_MASK(4'b0100), .RESET_VAL(32'h0)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1), .err(err1), .regs_o(regs1),
        .wr_pulse(wrp1), .hw_we(hw_we), .hw_wdata(hw_wdata));

    pmc_dc_reg_bank #(.NUM_REGS(4), .BASE_OFFSET(8'h00), .RSP_LATENCY(3),
                      .RO_MASK(4'b0100), .RESET_VAL(32'h0)) u3 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .err(err3), .regs_o(regs3),
        .wr_pulse(wrp3), .hw_we(hw_we), .hw_wdata(hw_wdata));

    pmc_dc_reg_bank #(.NUM_REGS(4), .BASE_OFFSET(8'h00), .RSP_LATENCY(2),
                      .RO_MASK(4'b0100), .RESET_VAL(32'h0)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2), .err(err2), .regs_o(regs2),
        .wr_pulse(wrp2), .hw_we(hw_we), .hw_wdata(hw_wdata));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One isolated access on the latency-1 instance; starts and ends just after a rising edge.
    task automatic access1(input string tag, input logic w, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic exp_err, input logic [31:0] exp_rd, input logic [3:0] exp_wrp);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        @(negedge clk);
        check_eq({tag, "/gnt"}, 64'(gnt1), 64'd1);
        check_eq({tag, "/early"}, 64'(rvalid1), 64'd0);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; be = 4'h0; hw_we = 4'h0;
        @(negedge clk);
        check_eq({tag, "/rvalid"}, 64'(rvalid1), 64'd1);
        check_eq({tag, "/err"}, 64'(err1), 64'(exp_err));
        check_eq({tag, "/rdata"}, 64'(rdata1), 64'(exp_rd));
        check_eq({tag, "/wr_pulse"}, 64'(wrp1), 64'(exp_wrp));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
        hw_we = 4'h0; hw_wdata = '0;

        #12;
        check_eq("rst/rvalid", 64'(rvalid1), 64'd0);
        check_eq("rst/rdata", 64'(rdata1), 64'd0);
        check_eq("rst/err", 64'(err1), 64'd0);
        check_eq("rst/wr_pulse", 64'(wrp1), 64'd0);
        check_eq("rst/regs_lo", regs1[63:0], 64'd0);
        check_eq("rst/regs_hi", regs1[127:64], 64'd0);
        check_eq("rst/rvalid3", 64'(rvalid3), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reads of every register after reset.
        access1("rd0", 1'b0, 4'h0, 32'h00, 32'h0, 1'b0, 32'h0, 4'h0);
        access1("rd1", 1'b0, 4'h0, 32'h04, 32'h0, 1'b0, 32'h0, 4'h0);
        access1("rd2", 1'b0, 4'h0, 32'h08, 32'h0, 1'b0, 32'h0, 4'h0);
        access1("rd3", 1'b0, 4'h0, 32'h0C, 32'h0, 1'b0, 32'h0, 4'h0);

        // Partial byte-enable write, readback through an alias with upper address bits set.
        access1("wr_be", 1'b1, 4'b0101, 32'h04, 32'hDEAD_BEEF, 1'b0, 32'h0, 4'b0010);
        check_eq("wr_be/regs1", 64'(regs1[63:32]), 64'h00AD_00EF);
        check_eq("wr_be/pulse_gone", 64'(wrp1), 64'd0);
        access1("rd_be", 1'b0, 4'h0, 32'h1234_5604, 32'h0, 1'b0, 32'h00AD_00EF, 4'h0);

        // Error responses: unmapped, misaligned, read-only.
        access1("rd_unmap", 1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 32'h0, 4'h0);
        access1("wr_unmap", 1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF, 1'b1, 32'h0, 4'h0);
        access1("rd_misal", 1'b0, 4'h0, 32'h05, 32'h0, 1'b1, 32'h0, 4'h0);
        access1("wr_misal", 1'b1, 4'hF, 32'h06, 32'hFFFF_FFFF, 1'b1, 32'h0, 4'h0);
        access1("wr_ro", 1'b1, 4'hF, 32'h08, 32'hFFFF_FFFF, 1'b1, 32'h0, 4'h0);
        check_eq("wr_ro/reg2", 64'(regs1[95:64]), 64'h0);
        check_eq("wr_misal/reg1", 64'(regs1[63:32]), 64'h00AD_00EF);

        // Hardware load of all registers, including the read-only one.
        hw_we = 4'hF;
        hw_wdata = {exp_tab[3], exp_tab[2], exp_tab[1], exp_tab[0]};
        @(posedge clk); #1;
        hw_we = 4'h0;
        @(negedge clk);
        check_eq("hw/reg2", 64'(regs1[95:64]), 64'h3333_3333);
        check_eq("hw/wr_pulse", 64'(wrp1), 64'd0);
        @(posedge clk); #1;

        // Eight back-to-back reads: latency-3 and latency-2 streams.
        for (int c = 0; c < 13; c++) begin
            req  = (c < 8);
            we   = 1'b0;
            addr = 32'(4 * (c % 4));
            @(negedge clk);
            check_eq($sformatf("b2b3/vld%0d", c), 64'(rvalid3), 64'(c >= 3 && c <= 10));
            check_eq($sformatf("b2b2/vld%0d", c), 64'(rvalid2), 64'(c >= 2 && c <= 9));
            if (c >= 3 && c <= 10) begin
                check_eq($sformatf("b2b3/dat%0d", c), 64'(rdata3), 64'(exp_tab[(c - 3) % 4]));
                check_eq($sformatf("b2b3/err%0d", c), 64'(err3), 64'd0);
            end
            @(posedge clk); #1;
        end

        // Same-cycle bus write and HW load on register 0.
        hw_we = 4'b0001;
        hw_wdata = {exp_tab[3], exp_tab[2], exp_tab[1], 32'hAABB_CCDD};
        access1("wr_hw", 1'b1, 4'b0011, 32'h00, 32'h1122_3344, 1'b0, 32'h0, 4'b0001);
        check_eq("wr_hw/reg0", 64'(regs1[31:0]), 64'hAABB_3344);

        // Read-after-write on consecutive cycles.
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0C; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        we = 1'b0;
        @(negedge clk);
        check_eq("raw/wr_rsp", 64'({rvalid1, err1}), 64'b10);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check_eq("raw/rd_vld", 64'(rvalid1), 64'd1);
        check_eq("raw/rd_dat", 64'(rdata1), 64'h1234_5678);
        @(posedge clk); #1;

        // Zero byte-enable write: succeeds, pulses, changes nothing.
        access1("wr_be0", 1'b1, 4'h0, 32'h0C, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'b1000);
        check_eq("wr_be0/reg3", 64'(regs1[127:96]), 64'h1234_5678);

        // Reset with two reads in flight on the latency-2 instance.
        req = 1'b1; we = 1'b0; addr = 32'h00;
        @(posedge clk); #1;
        addr = 32'h04;
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst/in_rst", 64'(rvalid2), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq($sformatf("midrst/vld%0d", c), 64'({rvalid1, rvalid2, rvalid3}), 64'd0);
        end
        check_eq("midrst/regs2_lo", regs2[63:0], 64'd0);
        check_eq("midrst/regs2_hi", regs2[127:64], 64'd0);
        check_eq("midrst/regs1_hi", regs1[127:64], 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pmc_dc_reg_bank.md
Name: pmc_dc_reg_bank

Overview:
- Parametrised register bank and bus slave for the PMC digital-configuration space.
- Generalises the single-register offset decoder in three ways:
  - supports N 32-bit registers at a configurable base offset;
  - supports writes with byte enables, read-only registers and hardware-side updates;
  - returns error responses and has a configurable, fully pipelined response latency.
- Sits between the SoC data-bus interconnect (OBI-style req/gnt/rvalid) and the PMC digital-configuration outputs.

Parameters:
- NUM_REGS, 4, number of 32-bit registers (1..64).
- BASE_OFFSET, 8'h00, byte offset of register 0 within the 256-byte window; word aligned; BASE_OFFSET + 4*NUM_REGS <= 256.
- RSP_LATENCY, 1, cycles from grant to rvalid (1..4).
- RO_MASK, {NUM_REGS{1'b0}}, bit i = 1 makes register i read-only from the bus.
- RESET_VAL, 32'h0000_0000, reset value of every register.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset: asynchronous, active-low.
- req  input  1  bus request.
- we  input  1  1 = write, 0 = read.
- be  input  4  byte enables for writes.
- addr  input  32  byte address; only addr[7:0] is decoded.
- wdata  input  32  write data.
- gnt  output  1  request accepted this cycle.
- rvalid  output  1  response valid.
- rdata  output  32  read data; valid when rvalid is 1.
- err  output  1  error response; valid when rvalid is 1.
- regs_o  output  NUM_REGS*32  current register contents; register i is regs_o[32*i +: 32].
- wr_pulse  output  NUM_REGS  one-cycle pulse after a successful bus write to register i.
- hw_we  input  NUM_REGS  hardware update strobe per register.
- hw_wdata  input  NUM_REGS*32  hardware update data.

Behaviour:
- Clock and reset: single clock domain, clk. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - all registers = RESET_VAL;
  - rvalid = 0, rdata = 0, err = 0, wr_pulse = 0;
  - the response pipeline is flushed.
- Grant: gnt = req, combinationally. Every request is accepted, one per cycle, and back-to-back requests are allowed.
- Address decode (on a granted request):
  - the request is mapped when addr[1:0] == 0 and BASE_OFFSET <= addr[7:0] < BASE_OFFSET + 4*NUM_REGS;
  - index = (addr[7:0] - BASE_OFFSET) >> 2, using 8-bit arithmetic;
  - addr[31:8] is ignored.
- Write (accepted, mapped, RO_MASK[index] = 0):
  - bytes with be[k] = 1 are updated at the clock edge ending the grant cycle;
  - bytes with be[k] = 0 are kept;
  - wr_pulse[index] = 1 in the following cycle only;
  - be = 0 still counts as a successful write: err = 0, wr_pulse fires, no data changes.
- Write error: a write that is unmapped, misaligned or targets a read-only register changes nothing and responds with err = 1, rdata = 0.
- Read:
  - mapped: rdata = register value sampled at the grant edge, err = 0;
  - unmapped or misaligned: rdata = 0, err = 1.
- Response pipeline:
  - RSP_LATENCY-deep shift register of {valid, err, rdata};
  - a response is produced exactly RSP_LATENCY cycles after its grant, in order, with no drops under continuous traffic;
  - write responses carry rdata = 0.
- Hardware update: hw_we[i] = 1 loads hw_wdata[i] at the clock edge. This applies to read-only registers too.
- Simultaneous bus write and hw_we to the same register: the bus write wins for the bytes enabled by be; the remaining bytes take hw_wdata.
- Read-after-write: a read granted the cycle after a write to the same register returns the new value.
- Reset mid-operation: in-flight responses are discarded and no rvalid is produced for them after reset release.

Test Plan:
- Reset, then read all NUM_REGS = 4 registers (addr 0x00, 0x04, 0x08, 0x0C) -> each returns 0x0000_0000 with err = 0; rvalid exactly 1 cycle after gnt.
- Write 0xDEADBEEF to 0x04 with be = 4'b0101, then read 0x04 -> 0x00AD00EF. wr_pulse[1] is high for one cycle; regs_o[63:32] = 0x00AD00EF.
- Accesses to 0x10 (unmapped), 0x05 (misaligned), and a write to RO register 2 (RO_MASK = 4'b0100) -> each responds err = 1, rdata = 0; register 2 is unchanged.
- RSP_LATENCY = 3, eight back-to-back reads -> eight rvalid pulses on consecutive cycles, starting 3 cycles after the first gnt, data in order.
- Same-cycle bus write 0x11223344 with be = 4'b0011 and hw_we[0] with 0xAABBCCDD -> register 0 = 0xAABB3344.
- Assert rst_n low while two reads are in flight (RSP_LATENCY = 2) -> no rvalid after release; registers = RESET_VAL.
